// File: rtl/gr_scoreboard_file.sv
// General-register file with write-back bypass and a per-register
// latency scoreboard that raises stall for the ID stage.
module gr_scoreboard_file #(
  parameter int WIDTH   = 16,
  parameter int NREG    = 8,
  parameter int AW      = 3,
  parameter int MAXLAT  = 3,
  parameter int CW      = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sb_clr,
  input  logic [AW-1:0]    ra_addr,
  input  logic             ra_used,
  output logic [WIDTH-1:0] ra_data,
  output logic             ra_busy,
  input  logic [AW-1:0]    rb_addr,
  input  logic             rb_used,
  output logic [WIDTH-1:0] rb_data,
  output logic             rb_busy,
  output logic             stall,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic [CW-1:0]    iss_lat,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [AW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic             sb_any
);

  localparam logic [CW-1:0] MAXC = CW'(MAXLAT);

  logic [WIDTH-1:0] gr  [NREG];
  logic [CW-1:0]    cnt [NREG];

  logic          wb_ok;
  logic          iss_ok;
  logic          a_r0, b_r0;
  logic          a_hit, b_hit;
  logic [CW-1:0] lat_sat;

  // r0 is a hard zero when ZERO_R0 is set: no write, no bypass, no busy
  assign wb_ok = enable && wb_en
               && !(ZERO_R0 != 0 && wb_addr == '0);

  assign a_r0  = (ZERO_R0 != 0) && (ra_addr == '0);
  assign b_r0  = (ZERO_R0 != 0) && (rb_addr == '0);
  assign a_hit = wb_ok && (wb_addr == ra_addr);
  assign b_hit = wb_ok && (wb_addr == rb_addr);

  assign ra_data = a_r0  ? '0
                 : a_hit ? wb_data
                 : gr[ra_addr];
  assign rb_data = b_r0  ? '0
                 : b_hit ? wb_data
                 : gr[rb_addr];

  assign ra_busy = !a_r0 && (cnt[ra_addr] != '0) && !a_hit;
  assign rb_busy = !b_r0 && (cnt[rb_addr] != '0) && !b_hit;

  assign stall = enable
               && ((ra_used && ra_busy) || (rb_used && rb_busy));

  assign dbg_data = gr[dbg_sel];

  assign lat_sat = (iss_lat > MAXC) ? MAXC : iss_lat;

  assign iss_ok = enable && iss_valid && !stall
               && (iss_lat != '0)
               && !(ZERO_R0 != 0 && iss_rd == '0);

  always_comb begin
    sb_any = 1'b0;
    for (int r = 0; r < NREG; r++)
      if (cnt[r] != '0) sb_any = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        gr[r]  <= '0;
        cnt[r] <= '0;
      end
    end else if (enable) begin
      for (int r = 0; r < NREG; r++) begin
        if (wb_ok && wb_addr == AW'(r))
          gr[r] <= wb_data;
        // a new issue owns the slot even if it retires on this edge
        if (sb_clr)
          cnt[r] <= '0;
        else if (iss_ok && iss_rd == AW'(r))
          cnt[r] <= lat_sat;
        else if (wb_en && wb_addr == AW'(r))
          cnt[r] <= '0;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gr_scoreboard_file.sv
// Randomised bench for gr_scoreboard_file: two instances (ZERO_R0 0/1)
// checked against a pending-latency reference model.
module tb_gr_scoreboard_file;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable, sb_clr;
  logic [2:0]  ra_addr, rb_addr, iss_rd, wb_addr, dbg_sel;
  logic        ra_used, rb_used, iss_valid, wb_en;
  logic [1:0]  iss_lat;
  logic [15:0] wb_data;

  logic [15:0] ra_data0, rb_data0, dbg_data0;
  logic        ra_busy0, rb_busy0, stall0, sb_any0;
  logic [15:0] ra_data1, rb_data1, dbg_data1;
  logic        ra_busy1, rb_busy1, stall1, sb_any1;

  int checks = 0;
  int failures = 0;

  logic [15:0] mgr  [2][8];
  int          mcnt [2][8];
  logic        mst  [2];

  always #5 clock = ~clock;

  gr_scoreboard_file #(.ZERO_R0(0)) u_d0 (
    .clock(clock), .reset(reset), .enable(enable), .sb_clr(sb_clr),
    .ra_addr(ra_addr), .ra_used(ra_used), .ra_data(ra_data0),
    .ra_busy(ra_busy0), .rb_addr(rb_addr), .rb_used(rb_used),
    .rb_data(rb_data0), .rb_busy(rb_busy0), .stall(stall0),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_lat(iss_lat),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data0), .sb_any(sb_any0)
  );

  gr_scoreboard_file #(.ZERO_R0(1)) u_d1 (
    .clock(clock), .reset(reset), .enable(enable), .sb_clr(sb_clr),
    .ra_addr(ra_addr), .ra_used(ra_used), .ra_data(ra_data1),
    .ra_busy(ra_busy1), .rb_addr(rb_addr), .rb_used(rb_used),
    .rb_data(rb_data1), .rb_busy(rb_busy1), .stall(stall1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_lat(iss_lat),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data1), .sb_any(sb_any1)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 8; r++) begin
        mgr[i][r]  = '0;
        mcnt[i][r] = 0;
      end
  endtask

  function automatic logic wb_hits(int i, logic [2:0] a);
    return enable && wb_en && wb_addr == a && !(i == 1 && a == 0);
  endfunction

  task automatic eval_chk(int i, logic [15:0] rad, logic [15:0] rbd,
                          logic [15:0] dbd, logic rab, logic rbb,
                          logic st, logic any);
    logic [15:0] ea, eb;
    logic ba, bb, e_any;
    ea = (i == 1 && ra_addr == 0) ? 16'h0
       : wb_hits(i, ra_addr) ? wb_data : mgr[i][ra_addr];
    eb = (i == 1 && rb_addr == 0) ? 16'h0
       : wb_hits(i, rb_addr) ? wb_data : mgr[i][rb_addr];
    ba = mcnt[i][ra_addr] > 0 && !wb_hits(i, ra_addr);
    bb = mcnt[i][rb_addr] > 0 && !wb_hits(i, rb_addr);
    mst[i] = enable && ((ra_used && ba) || (rb_used && bb));
    e_any = 1'b0;
    for (int r = 0; r < 8; r++) if (mcnt[i][r] > 0) e_any = 1'b1;
    chk($sformatf("ra_data%0d", i), 32'(rad), 32'(ea));
    chk($sformatf("rb_data%0d", i), 32'(rbd), 32'(eb));
    chk($sformatf("ra_busy%0d", i), 32'(rab), 32'(ba));
    chk($sformatf("rb_busy%0d", i), 32'(rbb), 32'(bb));
    chk($sformatf("stall%0d", i), 32'(st), 32'(mst[i]));
    chk($sformatf("dbg%0d", i), 32'(dbd), 32'(mgr[i][dbg_sel]));
    chk($sformatf("sb_any%0d", i), 32'(any), 32'(e_any));
  endtask

  task automatic model_step(int i);
    int lat;
    if (!enable) return;
    lat = (iss_lat > 3) ? 3 : int'(iss_lat);
    for (int r = 0; r < 8; r++) begin
      if (sb_clr)
        mcnt[i][r] = 0;
      else if (iss_valid && !mst[i] && iss_rd == r && lat != 0
               && !(i == 1 && r == 0))
        mcnt[i][r] = lat;
      else if (wb_en && wb_addr == r)
        mcnt[i][r] = 0;
      else if (mcnt[i][r] > 0)
        mcnt[i][r]--;
    end
    if (wb_en && !(i == 1 && wb_addr == 0))
      mgr[i][wb_addr] = wb_data;
  endtask

  // inputs are set at the falling edge; outputs sampled 2 time units later
  task automatic cycle();
    #2;
    eval_chk(0, ra_data0, rb_data0, dbg_data0,
             ra_busy0, rb_busy0, stall0, sb_any0);
    eval_chk(1, ra_data1, rb_data1, dbg_data1,
             ra_busy1, rb_busy1, stall1, sb_any1);
    @(posedge clock);
    model_step(0);
    model_step(1);
    @(negedge clock);
  endtask

  task automatic idle();
    enable = 1; sb_clr = 0;
    ra_used = 0; rb_used = 0;
    iss_valid = 0; wb_en = 0;
    iss_lat = 0; iss_rd = 0;
    wb_addr = 0; wb_data = 0;
  endtask

  initial begin
    idle();
    ra_addr = 0; rb_addr = 0; dbg_sel = 0;
    model_reset();
    repeat (2) @(negedge clock);
    cycle();
    reset = 1;
    @(negedge clock);
    cycle();

    // write r3 then make it pending, then reset mid-cycle
    wb_en = 1; wb_addr = 3; wb_data = 16'h1234;
    cycle();
    idle(); iss_valid = 1; iss_rd = 3; iss_lat = 2;
    cycle();
    idle(); ra_addr = 3; dbg_sel = 3;
    #2;
    chk("pre_rst_r3", 32'(dbg_data0), 32'h1234);
    reset = 0;
    #1;
    chk("rst_ra", 32'(ra_data0), 32'h0);
    chk("rst_busy", 32'(ra_busy0), 32'h0);
    chk("rst_any", 32'(sb_any0), 32'h0);
    model_reset();
    @(negedge clock);
    reset = 1;
    cycle();

    // LOAD-style latency on r2 with consumer right behind it
    iss_valid = 1; iss_rd = 2; iss_lat = 3;
    cycle();
    idle(); ra_addr = 2; ra_used = 1;
    #1 chk("t2_stall_a", 32'(stall0), 32'h1);
    cycle();
    #1 chk("t2_stall_b", 32'(stall0), 32'h1);
    cycle();
    wb_en = 1; wb_addr = 2; wb_data = 16'h00AB;
    #1 chk("t2_nostall", 32'(stall0), 32'h0);
    chk("t2_bypass", 32'(ra_data0), 32'h00AB);
    cycle();
    idle(); dbg_sel = 2;
    #1 chk("t2_stored", 32'(dbg_data0), 32'h00AB);
    cycle();

    // busy without use does not stall
    iss_valid = 1; iss_rd = 5; iss_lat = 3;
    cycle();
    idle(); ra_addr = 5;
    #1 chk("t3_busy", 32'(ra_busy0), 32'h1);
    chk("t3_nostall", 32'(stall0), 32'h0);
    rb_addr = 5; rb_used = 1;
    #1 chk("t3_stall", 32'(stall0), 32'h1);
    cycle();
    idle(); sb_clr = 1;
    cycle();

    // same-edge issue and write-back on r4: issue wins
    idle(); wb_en = 1; wb_addr = 4; wb_data = 16'h0011;
    iss_valid = 1; iss_rd = 4; iss_lat = 2;
    cycle();
    idle(); rb_addr = 4; dbg_sel = 4;
    #1 chk("t4_busy", 32'(rb_busy0), 32'h1);
    chk("t4_data", 32'(dbg_data0), 32'h0011);
    cycle();
    cycle();

    // hard-zero r0 instance
    wb_en = 1; wb_addr = 0; wb_data = 16'hFFFF;
    cycle();
    idle(); iss_valid = 1; iss_rd = 0; iss_lat = 3;
    cycle();
    idle(); ra_addr = 0; ra_used = 1;
    #1 chk("t5_r0", 32'(ra_data1), 32'h0);
    chk("t5_busy", 32'(ra_busy1), 32'h0);
    chk("t5_stall", 32'(stall1), 32'h0);
    cycle();

    // frozen pipeline
    idle(); iss_valid = 1; iss_rd = 1; iss_lat = 2;
    cycle();
    idle(); enable = 0; wb_en = 1; wb_addr = 1; wb_data = 16'h5555;
    ra_addr = 1; ra_used = 1; dbg_sel = 1;
    repeat (4) cycle();
    #1 chk("t6_frozen_busy", 32'(ra_busy0), 32'h1);
    chk("t6_frozen_stall", 32'(stall0), 32'h0);
    idle(); sb_clr = 1;
    cycle();
    idle();
    #1 chk("t6_clr_any", 32'(sb_any0), 32'h0);
    cycle();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      enable    = ($urandom_range(0, 9) != 0);
      sb_clr    = ($urandom_range(0, 39) == 0);
      ra_addr   = 3'($urandom);
      rb_addr   = 3'($urandom);
      ra_used   = 1'($urandom);
      rb_used   = 1'($urandom);
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd    = 3'($urandom);
      iss_lat   = 2'($urandom);
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_addr   = 3'($urandom);
      wb_data   = 16'($urandom);
      dbg_sel   = 3'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
